sdram_arbiter: RTL and testbench

- Owns the SDRAM command bus (command/address/bank/cke).
- Runs the power-up init sequence and the periodic auto-refresh timer.
- Grants the bus to either the read engine or the write engine; both engines share the same command/idle/auto_refresh/wait_for_refresh interface.
- Sits between the Wishbone SDRAM top level and the read/write engines. The bus muxes straight to the SDRAM pins.

---
 rtl/sdram_arbiter_pkg.sv | 40 ++++
 rtl/sdram_refresh_timer.sv | 47 ++++
 rtl/sdram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// rtl/sdram_arbiter_pkg.sv - SDRAM command encodings, timing constants and arbiter types
package sdram_arbiter_pkg;

  // SDRAM command encodings as {ras_n, cas_n, we_n}
  localparam logic [2:0] SDRAM_CMD_NOP   = 3'b111;
  localparam logic [2:0] SDRAM_CMD_ACT   = 3'b011;
  localparam logic [2:0] SDRAM_CMD_READ  = 3'b101;
  localparam logic [2:0] SDRAM_CMD_WRITE = 3'b100;
  localparam logic [2:0] SDRAM_CMD_TERM  = 3'b110;
  localparam logic [2:0] SDRAM_CMD_PRE   = 3'b010;
  localparam logic [2:0] SDRAM_CMD_AR    = 3'b001;
  localparam logic [2:0] SDRAM_CMD_LMR   = 3'b000;

  // Command-to-next-command spacing in clk cycles, shared with the engines
  localparam int T_RP  = 2;
  localparam int T_RFC = 7;
  localparam int T_MRD = 2;

  // PRE with address[10] set closes every bank
  localparam logic [11:0] ADDR_PRE_ALL = 12'h400;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_AR1,
    ST_INIT_AR2,
    ST_INIT_LMR,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_REF_PRE,
    ST_REF_AR
  } arb_state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - periodic auto-refresh down-counter with sticky pending flag
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 1560
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic ack_i,
  output logic refresh_pending_o,
  output logic refresh_due_o
);

  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic          expire;

  // Expiry is one cycle at count zero; it never queues more than one refresh
  assign expire = enable_i && (count_q == '0);

  // Next count and pending; a new expiry wins over an ack in the same cycle
  always_comb begin
    count_d   = count_q;
    pending_d = expire | (pending_q & ~ack_i);
    if (enable_i) begin
      count_d = expire ? RELOAD : count_q - CW'(1);
    end
  end

  // Timer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign refresh_pending_o = pending_q;
  // Lets the arbiter see an expiry in the very cycle it happens
  assign refresh_due_o     = pending_q | expire;

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM command bus owner: init, auto-refresh and read/write engine grant
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int          INIT_DELAY       = 20000,
  parameter int          REFRESH_INTERVAL = 1560,
  parameter logic [11:0] MODE_REG         = 12'h027
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        app_read_req,
  input  logic        app_write_req,
  output logic        rd_enable,
  input  logic [2:0]  rd_command,
  input  logic [11:0] rd_address,
  input  logic [1:0]  rd_bank,
  input  logic        rd_idle,
  output logic        wr_enable,
  input  logic [2:0]  wr_command,
  input  logic [11:0] wr_address,
  input  logic [1:0]  wr_bank,
  input  logic        wr_idle,
  output logic        auto_refresh,
  output logic [2:0]  command,
  output logic [11:0] address,
  output logic [1:0]  bank,
  output logic        cke,
  output logic        ready
);

  localparam int DELAY_W = $clog2(INIT_DELAY + 16);

  arb_state_e         state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [11:0]        addr_q, addr_d;
  logic [1:0]         bank_q, bank_d;
  logic               ready_q, ready_d;
  logic               cke_q;
  grant_e             last_grant_q, last_grant_d;

  logic refresh_pending;
  logic refresh_due;
  logic refresh_ack;
  logic rd_exit;
  logic wr_exit;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (ready_q),
    .ack_i            (refresh_ack),
    .refresh_pending_o(refresh_pending),
    .refresh_due_o    (refresh_due)
  );

  // An engine is released once it is idle and the host is done or a refresh is waiting
  assign rd_exit = rd_idle && (!app_read_req || refresh_pending);
  assign wr_exit = wr_idle && (!app_write_req || refresh_pending);

  // Next-state logic: init sequence, refresh sequence and grant decisions
  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    cmd_d        = SDRAM_CMD_NOP;
    addr_d       = '0;
    bank_d       = '0;
    ready_d      = ready_q;
    last_grant_d = last_grant_q;
    refresh_ack  = 1'b0;
    if (delay_q != '0) begin
      delay_d = delay_q - DELAY_W'(1);
    end else begin
      case (state_q)
        ST_INIT_WAIT: begin
          delay_d = DELAY_W'(INIT_DELAY - 1);
          state_d = ST_INIT_PRE;
        end
        ST_INIT_PRE: begin
          cmd_d   = SDRAM_CMD_PRE;
          addr_d  = ADDR_PRE_ALL;
          delay_d = DELAY_W'(T_RP - 1);
          state_d = ST_INIT_AR1;
        end
        ST_INIT_AR1: begin
          cmd_d   = SDRAM_CMD_AR;
          delay_d = DELAY_W'(T_RFC - 1);
          state_d = ST_INIT_AR2;
        end
        ST_INIT_AR2: begin
          cmd_d   = SDRAM_CMD_AR;
          delay_d = DELAY_W'(T_RFC - 1);
          state_d = ST_INIT_LMR;
        end
        ST_INIT_LMR: begin
          cmd_d   = SDRAM_CMD_LMR;
          addr_d  = MODE_REG;
          delay_d = DELAY_W'(T_MRD - 1);
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          ready_d = 1'b1;
          if (refresh_due) begin
            state_d = ST_REF_PRE;
          end else if (app_read_req && (!app_write_req || last_grant_q == GRANT_WRITE)) begin
            state_d      = ST_READ;
            last_grant_d = GRANT_READ;
          end else if (app_write_req) begin
            state_d      = ST_WRITE;
            last_grant_d = GRANT_WRITE;
          end
        end
        ST_READ: begin
          if (rd_exit) state_d = ST_IDLE;
        end
        ST_WRITE: begin
          if (wr_exit) state_d = ST_IDLE;
        end
        ST_REF_PRE: begin
          cmd_d   = SDRAM_CMD_PRE;
          addr_d  = ADDR_PRE_ALL;
          delay_d = DELAY_W'(T_RP - 1);
          state_d = ST_REF_AR;
        end
        ST_REF_AR: begin
          cmd_d       = SDRAM_CMD_AR;
          refresh_ack = 1'b1;
          delay_d     = DELAY_W'(T_RFC - 1);
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_INIT_WAIT;
        end
      endcase
    end
  end

  // Arbiter state and registered command bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT_WAIT;
      delay_q      <= '0;
      cmd_q        <= SDRAM_CMD_NOP;
      addr_q       <= '0;
      bank_q       <= '0;
      ready_q      <= 1'b0;
      cke_q        <= 1'b0;
      last_grant_q <= GRANT_WRITE;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      bank_q       <= bank_d;
      ready_q      <= ready_d;
      cke_q        <= 1'b1;
      last_grant_q <= last_grant_d;
    end
  end

  // Pin mux: a granted engine drives the bus with no added latency
  always_comb begin
    rd_enable = 1'b0;
    wr_enable = 1'b0;
    command   = cmd_q;
    address   = addr_q;
    bank      = bank_q;
    case (state_q)
      ST_READ: begin
        rd_enable = app_read_req && !rd_exit;
        command   = rd_command;
        address   = rd_address;
        bank      = rd_bank;
      end
      ST_WRITE: begin
        wr_enable = app_write_req && !wr_exit;
        command   = wr_command;
        address   = wr_address;
        bank      = wr_bank;
      end
      default: begin
      end
    endcase
  end

  assign auto_refresh = refresh_pending;
  assign cke          = cke_q;
  assign ready        = ready_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - randomized bench for sdram_arbiter against a timestamp-based reference model
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int          ID = 10;
  localparam int          RI = 100;
  localparam logic [11:0] MR = 12'h027;

  localparam int M_BUSY = 0, M_IDLE = 1, M_READ = 2, M_WRITE = 3;
  localparam int PH_RST = 0, PH_QUIET = 1, PH_READ = 2, PH_CONT = 3, PH_RAND = 4, PH_WRREQ = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        app_read_req = 1'b0, app_write_req = 1'b0;
  logic [2:0]  rd_command = 3'b111, wr_command = 3'b111;
  logic [11:0] rd_address = '0, wr_address = '0;
  logic [1:0]  rd_bank = '0, wr_bank = '0;
  logic        rd_idle = 1'b1, wr_idle = 1'b1;
  logic        rd_enable, wr_enable, auto_refresh, cke, ready;
  logic [2:0]  command;
  logic [11:0] address;
  logic [1:0]  bank;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .INIT_DELAY(ID), .REFRESH_INTERVAL(RI), .MODE_REG(MR)
  ) dut (
    .clk(clk), .rst(rst),
    .app_read_req(app_read_req), .app_write_req(app_write_req),
    .rd_enable(rd_enable), .rd_command(rd_command), .rd_address(rd_address),
    .rd_bank(rd_bank), .rd_idle(rd_idle),
    .wr_enable(wr_enable), .wr_command(wr_command), .wr_address(wr_address),
    .wr_bank(wr_bank), .wr_idle(wr_idle),
    .auto_refresh(auto_refresh), .command(command), .address(address),
    .bank(bank), .cke(cke), .ready(ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: commands are timestamped by edge number since reset release
  typedef struct {
    int          at;
    logic [2:0]  cmd;
    logic [11:0] addr;
  } sched_t;

  sched_t      sched[$];
  int          cyc, m_mode, m_free, m_rdy_edge;
  bit          m_cke, m_ready, m_pend, m_last;
  logic [2:0]  m_cmd;
  logic [11:0] m_addr;
  logic [1:0]  m_bank;
  int          rd_hold, wr_hold;

  task automatic model_edge();
    bit     exp_now, due, ack, idle_act;
    sched_t sc;
    if (rst) begin
      cyc = -1; m_mode = M_BUSY; m_free = -1; m_rdy_edge = -1;
      m_cke = 0; m_ready = 0; m_pend = 0; m_last = 1;
      m_cmd = SDRAM_CMD_NOP; m_addr = '0; m_bank = '0;
      sched.delete();
      return;
    end
    cyc++;
    if (cyc == 0) begin
      m_cke = 1;
      sched.push_back('{at: ID,                    cmd: SDRAM_CMD_PRE, addr: 12'h400});
      sched.push_back('{at: ID + T_RP,             cmd: SDRAM_CMD_AR,  addr: 12'h000});
      sched.push_back('{at: ID + T_RP + T_RFC,     cmd: SDRAM_CMD_AR,  addr: 12'h000});
      sched.push_back('{at: ID + T_RP + 2 * T_RFC, cmd: SDRAM_CMD_LMR, addr: MR});
      m_free = ID + T_RP + 2 * T_RFC + T_MRD;
    end
    exp_now = m_ready && (((cyc - m_rdy_edge) % RI) == 0);
    due = m_pend | exp_now;
    ack = 0;
    idle_act = 0;
    m_cmd = SDRAM_CMD_NOP; m_addr = '0; m_bank = '0;
    if (sched.size() > 0 && sched[0].at == cyc) begin
      sc = sched.pop_front();
      m_cmd = sc.cmd;
      m_addr = sc.addr;
      ack = (sc.cmd == SDRAM_CMD_AR);
    end
    case (m_mode)
      M_BUSY:  idle_act = (cyc == m_free);
      M_IDLE:  idle_act = 1;
      M_READ:  if (rd_idle && (!app_read_req || m_pend)) m_mode = M_IDLE;
      M_WRITE: if (wr_idle && (!app_write_req || m_pend)) m_mode = M_IDLE;
      default: ;
    endcase
    if (idle_act) begin
      m_mode = M_IDLE;
      if (!m_ready) begin
        m_ready = 1;
        m_rdy_edge = cyc;
      end
      if (due) begin
        m_mode = M_BUSY;
        sched.push_back('{at: cyc + 1,        cmd: SDRAM_CMD_PRE, addr: 12'h400});
        sched.push_back('{at: cyc + 1 + T_RP, cmd: SDRAM_CMD_AR,  addr: 12'h000});
        m_free = cyc + 1 + T_RP + T_RFC;
      end else if (app_read_req && app_write_req) begin
        m_mode = m_last ? M_READ : M_WRITE;
        m_last = !m_last;
      end else if (app_read_req) begin
        m_mode = M_READ; m_last = 0;
      end else if (app_write_req) begin
        m_mode = M_WRITE; m_last = 1;
      end
    end
    m_pend = exp_now | (m_pend & !ack);
  endtask

  task automatic check_outputs();
    logic [2:0]  ec;
    logic [11:0] ea;
    logic [1:0]  eb;
    bit          erd, ewr;
    ec = m_cmd; ea = m_addr; eb = m_bank; erd = 0; ewr = 0;
    if (m_mode == M_READ) begin
      ec = rd_command; ea = rd_address; eb = rd_bank;
      erd = app_read_req && !(rd_idle && m_pend);
    end else if (m_mode == M_WRITE) begin
      ec = wr_command; ea = wr_address; eb = wr_bank;
      ewr = app_write_req && !(wr_idle && m_pend);
    end
    check("command", command, ec);
    check("address", address, ea);
    check("bank", bank, eb);
    check("cke", cke, m_cke);
    check("ready", ready, m_ready);
    check("auto_refresh", auto_refresh, m_pend);
    check("rd_enable", rd_enable, erd);
    check("wr_enable", wr_enable, ewr);
    check("enable_overlap", rd_enable & wr_enable, 0);
  endtask

  task automatic drive(input int ph);
    rd_command = 3'($urandom); rd_address = 12'($urandom); rd_bank = 2'($urandom);
    wr_command = 3'($urandom); wr_address = 12'($urandom); wr_bank = 2'($urandom);
    rst = (ph == PH_RST);
    case (ph)
      PH_READ: begin
        app_read_req = 1; app_write_req = 0;
        rd_idle = 1'($urandom_range(1)); wr_idle = 1;
      end
      PH_CONT: begin
        rd_idle = 1; wr_idle = 1;
        if (m_mode == M_READ) rd_hold++; else rd_hold = 0;
        if (m_mode == M_WRITE) wr_hold++; else wr_hold = 0;
        app_read_req  = (m_mode == M_READ)  ? (rd_hold < 3) : 1'b1;
        app_write_req = (m_mode == M_WRITE) ? (wr_hold < 3) : 1'b1;
      end
      PH_RAND: begin
        if ($urandom_range(7) == 0) app_read_req = !app_read_req;
        if ($urandom_range(7) == 0) app_write_req = !app_write_req;
        rd_idle = ($urandom_range(3) != 0);
        wr_idle = ($urandom_range(3) != 0);
      end
      PH_WRREQ: begin
        app_read_req = 0; app_write_req = 1;
        rd_idle = 1; wr_idle = 1'($urandom_range(1));
      end
      default: begin
        app_read_req = 0; app_write_req = 0; rd_idle = 1; wr_idle = 1;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle_check();
    #1;
    check_outputs();
  endtask

  task automatic step(input int ph);
    tick();
    drive(ph);
    settle_check();
  endtask

  initial begin
    bit found;
    rd_hold = 0; wr_hold = 0;
    repeat (3) step(PH_RST);
    repeat (40) step(PH_QUIET);
    check("ready_after_init", ready, 1);
    repeat (20) step(PH_READ);
    repeat (5) step(PH_QUIET);
    repeat (60) step(PH_CONT);
    repeat (2500) step(PH_RAND);
    repeat (15) step(PH_QUIET);

    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      drive(PH_QUIET);
      if (m_mode == M_IDLE && m_ready && !m_pend && (((cyc + 1 - m_rdy_edge) % RI) == 0)) begin
        app_write_req = 1;
        found = 1;
      end
      settle_check();
    end
    check("simul_window_found", found, 1);
    repeat (30) step(PH_WRREQ);

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_mode == M_WRITE) begin
        drive(PH_RST);
        found = 1;
      end else begin
        drive(PH_WRREQ);
      end
      settle_check();
    end
    check("write_before_reset", found, 1);
    step(PH_QUIET);
    check("ready_low_after_reset", ready, 0);
    repeat (50) step(PH_QUIET);
    check("ready_after_reinit", ready, 1);
    repeat (200) step(PH_RAND);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
